// File: rtl/ika87ad_irq_pkg.sv
// Shared definitions for the IKA87AD interrupt arbiter: source codes, vector table, group pairs, FSM states.
// Latency: none. Package contents are constants and pure functions only.
// Backpressure: not applicable.
package ika87ad_irq_pkg;

  localparam int CODE_W   = 5;
  localparam int VEC_W    = 16;
  localparam int NSRC_DEF = 11;

  // Source codes; the code is also the priority (0 = highest).
  localparam logic [CODE_W-1:0] SRC_NMI    = 5'd0;
  localparam logic [CODE_W-1:0] SRC_INTT0  = 5'd1;
  localparam logic [CODE_W-1:0] SRC_INTT1  = 5'd2;
  localparam logic [CODE_W-1:0] SRC_INT1   = 5'd3;
  localparam logic [CODE_W-1:0] SRC_INT2   = 5'd4;
  localparam logic [CODE_W-1:0] SRC_INTE0  = 5'd5;
  localparam logic [CODE_W-1:0] SRC_INTE1  = 5'd6;
  localparam logic [CODE_W-1:0] SRC_INTEIN = 5'd7;
  localparam logic [CODE_W-1:0] SRC_INTAD  = 5'd8;
  localparam logic [CODE_W-1:0] SRC_INTSR  = 5'd9;
  localparam logic [CODE_W-1:0] SRC_INTST  = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } irq_state_t;

  // Fixed vector address for each source; paired sources share one vector.
  function automatic logic [VEC_W-1:0] irq_vector(input logic [CODE_W-1:0] code);
    logic [VEC_W-1:0] v;
    case (code)
      SRC_NMI:               v = 16'h0004;
      SRC_INTT0, SRC_INTT1:  v = 16'h0008;
      SRC_INT1, SRC_INT2:    v = 16'h0010;
      SRC_INTE0, SRC_INTE1:  v = 16'h0018;
      SRC_INTEIN, SRC_INTAD: v = 16'h0020;
      SRC_INTSR, SRC_INTST:  v = 16'h0028;
      default:               v = 16'h0000;
    endcase
    return v;
  endfunction

  // Group pair table: group g holds sources (2g+1, 2g+2). NMI belongs to no group.
  function automatic int grp_lo(input int g);
    return 2 * g + 1;
  endfunction

  function automatic int grp_hi(input int g);
    return 2 * g + 2;
  endfunction

endpackage

// File: rtl/ika87ad_irq_prienc.sv
// Priority encoder: reports whether any request bit is set and the lowest set index.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module ika87ad_irq_prienc #(
  parameter int N = 11,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  output logic         vld,
  output logic [W-1:0] idx
);

  // Scan downward so the lowest set index is the last assignment to stick.
  always_comb begin
    vld = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) idx = W'(k);
    end
  end

endmodule

// File: rtl/ika87ad_irq_arbiter.sv
// Interrupt arbiter: picks highest-priority eligible flag, presents code/vector, generates auto/manual acks.
// Latency: request 1 cycle after sample tick; acks combinational on the ack tick from registered state.
// Backpressure: request is held until the CPU accepts or the winner withdraws; SKIT slot holds one code.
module ika87ad_irq_arbiter
  import ika87ad_irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic              i_EMUCLK,
  input  logic              i_MRST,
  input  logic              i_SAMPLETICK,
  input  logic              i_RSTTICK,
  input  logic [NSRC-1:0]   i_IFLAG,
  input  logic [NSRC-1:0]   i_MASK,
  input  logic              i_IE,
  input  logic              i_IRQ_ACCEPT,
  input  logic              i_SKIT,
  input  logic [CODE_W-1:0] i_SKIT_CODE,
  output logic              o_IRQ_REQ,
  output logic [CODE_W-1:0] o_IRQ_CODE,
  output logic [VEC_W-1:0]  o_IRQ_VECTOR,
  output logic              o_IE_CLR,
  output logic [NSRC-1:0]   o_AUTO_ACK,
  output logic              o_MANUAL_ACK,
  output logic [CODE_W-1:0] o_ACK_CODE,
  output logic [NSRC-1:0]   o_MULTI_IRQ_ENABLED
);

  localparam int NGRP = (NSRC - 1) / 2;

  irq_state_t        state, state_nxt;
  logic              latch_ld;
  logic [NSRC-1:0]   multi_en;
  logic [NSRC-1:0]   elig;
  logic              win_vld;
  logic [CODE_W-1:0] win_idx;
  logic [CODE_W-1:0] code_q;
  logic [VEC_W-1:0]  vec_q;
  logic              ie_clr_q;
  logic [NSRC-1:0]   code_oh;
  logic              code_multi;
  logic              slot_vld;
  logic [CODE_W-1:0] slot_code;
  logic              unused_mask0;

  // NMI cannot be masked, so its mask bit carries no meaning.
  assign unused_mask0 = i_MASK[0];

  // A source shares its vector (left for SKIT) only when both members of its pair are unmasked.
  always_comb begin
    multi_en = '0;
    for (int g = 0; g < NGRP; g++) begin
      multi_en[grp_lo(g)] = ~i_MASK[grp_lo(g)] & ~i_MASK[grp_hi(g)];
      multi_en[grp_hi(g)] = ~i_MASK[grp_lo(g)] & ~i_MASK[grp_hi(g)];
    end
  end

  assign o_MULTI_IRQ_ENABLED = multi_en;

  // NMI bypasses both mask and global enable; everything else needs both.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (k == 0) elig[k] = i_IFLAG[k];
      else        elig[k] = i_IFLAG[k] & ~i_MASK[k] & i_IE;
    end
  end

  ika87ad_irq_prienc #(
    .N (NSRC),
    .W (CODE_W)
  ) u_prienc (
    .req (elig),
    .vld (win_vld),
    .idx (win_idx)
  );

  // State register.
  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept beats a same-cycle sample; re-arbitration in REQ always tracks the current winner.
  always_comb begin
    state_nxt = state;
    latch_ld  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_SAMPLETICK && win_vld) begin
          state_nxt = ST_REQ;
          latch_ld  = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_IRQ_ACCEPT) begin
          state_nxt = ST_ACK;
        end else if (i_SAMPLETICK) begin
          if (win_vld) latch_ld  = 1'b1;
          else         state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (i_RSTTICK) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Winner latch: code and vector held stable for the CPU through REQ and ACK.
  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      code_q <= '0;
      vec_q  <= '0;
    end else if (latch_ld) begin
      code_q <= win_idx;
      vec_q  <= irq_vector(win_idx);
    end
  end

  // IE clear pulses in the first ACK cycle, the same cycle the request drops.
  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) ie_clr_q <= 1'b0;
    else        ie_clr_q <= (state == ST_REQ) && i_IRQ_ACCEPT;
  end

  // SKIT slot: a new SKIT overwrites; the ack tick consumes it unless a SKIT lands in that same cycle.
  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      slot_vld  <= 1'b0;
      slot_code <= '0;
    end else if (i_SKIT) begin
      slot_vld  <= 1'b1;
      slot_code <= i_SKIT_CODE;
    end else if (i_RSTTICK) begin
      slot_vld  <= 1'b0;
    end
  end

  assign code_oh    = NSRC'(1) << code_q;
  assign code_multi = |(multi_en & code_oh);

  // Outputs: request from state; acks only exist during the ack tick itself.
  always_comb begin
    o_IRQ_REQ  = (state == ST_REQ);
    o_AUTO_ACK = '0;
    if ((state == ST_ACK) && i_RSTTICK && ((code_q == SRC_NMI) || !code_multi)) begin
      o_AUTO_ACK = code_oh;
    end
    o_MANUAL_ACK = slot_vld & i_RSTTICK;
    o_ACK_CODE   = (slot_vld & i_RSTTICK) ? slot_code : '0;
  end

  assign o_IRQ_CODE   = code_q;
  assign o_IRQ_VECTOR = vec_q;
  assign o_IE_CLR     = ie_clr_q;

endmodule

// File: tb/tb_ika87ad_irq_arbiter.sv
// Self-checking bench for ika87ad_irq_arbiter: directed scenarios, then randomized traffic against a reference model.
// Latency: model predicts outputs for each cycle from inputs and its own request/ack bookkeeping.
// Backpressure: not applicable.
module tb_ika87ad_irq_arbiter;

  logic        clk;
  logic        mrst;
  logic        sample;
  logic        rsttick;
  logic [10:0] iflag;
  logic [10:0] mask;
  logic        ie;
  logic        accept;
  logic        skit;
  logic [4:0]  skit_code;
  logic        irq_req;
  logic [4:0]  irq_code;
  logic [15:0] irq_vector;
  logic        ie_clr;
  logic [10:0] auto_ack;
  logic        manual_ack;
  logic [4:0]  ack_code;
  logic [10:0] multi_en;

  int checks;
  int failures;

  // Reference model bookkeeping
  bit m_req;
  bit m_ack;
  int m_code;
  int m_vec;
  bit m_ieclr;
  bit m_slot_v;
  int m_slot_c;
  int vtab [11] = '{4, 8, 8, 16, 16, 24, 24, 32, 32, 40, 40};

  ika87ad_irq_arbiter #(.NSRC(11)) dut (
    .i_EMUCLK            (clk),
    .i_MRST              (mrst),
    .i_SAMPLETICK        (sample),
    .i_RSTTICK           (rsttick),
    .i_IFLAG             (iflag),
    .i_MASK              (mask),
    .i_IE                (ie),
    .i_IRQ_ACCEPT        (accept),
    .i_SKIT              (skit),
    .i_SKIT_CODE         (skit_code),
    .o_IRQ_REQ           (irq_req),
    .o_IRQ_CODE          (irq_code),
    .o_IRQ_VECTOR        (irq_vector),
    .o_IE_CLR            (ie_clr),
    .o_AUTO_ACK          (auto_ack),
    .o_MANUAL_ACK        (manual_ack),
    .o_ACK_CODE          (ack_code),
    .o_MULTI_IRQ_ENABLED (multi_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest-numbered flag that is allowed through; -1 if none.
  function automatic int model_winner();
    for (int k = 0; k < 11; k++) begin
      if (iflag[k] && (k == 0 || (!mask[k] && ie))) return k;
    end
    return -1;
  endfunction

  // Source k (k>0) belongs to group (k+1)/2 whose members are 2g-1 and 2g.
  function automatic logic [10:0] model_multi();
    logic [10:0] r;
    r = '0;
    for (int k = 1; k < 11; k++) begin
      int g;
      g = (k + 1) / 2;
      r[k] = !mask[2*g-1] && !mask[2*g];
    end
    return r;
  endfunction

  task automatic check_model();
    logic [10:0] mm;
    logic [10:0] exp_auto;
    bit          exp_man;
    mm       = model_multi();
    exp_auto = '0;
    if (m_ack && rsttick && (m_code == 0 || !mm[m_code])) exp_auto = 11'(1) << m_code;
    exp_man = m_slot_v && rsttick;
    chk("req",      32'(irq_req),    32'(m_req));
    chk("code",     32'(irq_code),   32'(m_code));
    chk("vector",   32'(irq_vector), 32'(m_vec));
    chk("ie_clr",   32'(ie_clr),     32'(m_ieclr));
    chk("auto_ack", 32'(auto_ack),   32'(exp_auto));
    chk("man_ack",  32'(manual_ack), 32'(exp_man));
    chk("ack_code", 32'(ack_code),   exp_man ? 32'(m_slot_c) : 32'd0);
    chk("multi",    32'(multi_en),   32'(mm));
  endtask

  task automatic update_model();
    int w;
    bit nxt_ieclr;
    if (mrst) begin
      m_req = 0; m_ack = 0; m_code = 0; m_vec = 0; m_ieclr = 0; m_slot_v = 0; m_slot_c = 0;
    end else begin
      w = model_winner();
      nxt_ieclr = m_req && accept;
      if (m_req && accept) begin
        m_req = 0;
        m_ack = 1;
      end else if (m_req && sample) begin
        if (w >= 0) begin
          m_code = w;
          m_vec  = vtab[w];
        end else begin
          m_req = 0;
        end
      end else if (!m_req && !m_ack && sample && w >= 0) begin
        m_req  = 1;
        m_code = w;
        m_vec  = vtab[w];
      end else if (m_ack && rsttick) begin
        m_ack = 0;
      end
      m_ieclr = nxt_ieclr;
      if (skit) begin
        m_slot_v = 1;
        m_slot_c = int'(skit_code);
      end else if (rsttick) begin
        m_slot_v = 0;
      end
    end
  endtask

  // One clock: compare against the model mid-cycle, advance model and DUT, then drop the pulses.
  task automatic tick();
    #1;
    check_model();
    update_model();
    @(posedge clk);
    @(negedge clk);
    sample = 0; rsttick = 0; accept = 0; skit = 0; mrst = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    mrst = 1; sample = 0; rsttick = 0; iflag = '0; mask = '0; ie = 0;
    accept = 0; skit = 0; skit_code = '0;
    @(posedge clk);
    @(negedge clk);
    m_req = 0; m_ack = 0; m_code = 0; m_vec = 0; m_ieclr = 0; m_slot_v = 0; m_slot_c = 0;
    mrst = 0;

    // Reset state
    chk("rst_req",  32'(irq_req),    32'd0);
    chk("rst_code", 32'(irq_code),   32'd0);
    chk("rst_vec",  32'(irq_vector), 32'd0);
    chk("rst_ieclr", 32'(ie_clr),    32'd0);
    rsttick = 1;
    #1 chk("rst_noack", 32'({auto_ack, manual_ack}), 32'd0);
    tick();

    // NMI ignores IE and mask
    iflag = 11'h001; ie = 0; mask = 11'h7FF; sample = 1; tick();
    chk("nmi_req",  32'(irq_req),    32'd1);
    chk("nmi_code", 32'(irq_code),   32'd0);
    chk("nmi_vec",  32'(irq_vector), 32'h0004);
    accept = 1; tick();
    chk("nmi_ieclr", 32'(ie_clr),  32'd1);
    chk("nmi_req_fall", 32'(irq_req), 32'd0);
    rsttick = 1;
    #1 chk("nmi_auto", 32'(auto_ack), 32'h001);
    tick();
    iflag = '0; tick();
    chk("nmi_ieclr_once", 32'(ie_clr), 32'd0);
    mrst = 1; tick();

    // Mask and global enable
    iflag = 11'h008; mask = 11'h008; ie = 1; sample = 1; tick();
    chk("masked_noreq", 32'(irq_req), 32'd0);
    mask = '0; ie = 0; sample = 1; tick();
    chk("ie0_noreq", 32'(irq_req), 32'd0);
    ie = 1; sample = 1; tick();
    chk("ie1_req",  32'(irq_req),    32'd1);
    chk("ie1_code", 32'(irq_code),   32'd3);
    chk("ie1_vec",  32'(irq_vector), 32'h0010);
    mrst = 1; tick();

    // Priority and re-arbitration
    iflag = 11'h600; mask = '0; ie = 1; sample = 1; tick();
    chk("pri_code9", 32'(irq_code), 32'd9);
    iflag = 11'h602; sample = 1; tick();
    chk("pri_code1", 32'(irq_code),   32'd1);
    chk("pri_vec1",  32'(irq_vector), 32'h0008);
    mrst = 1; tick();

    // Shared-vector source left for SKIT
    iflag = 11'h020; mask = '0; ie = 1; sample = 1; tick();
    accept = 1; tick();
    rsttick = 1;
    #1 chk("multi_noauto", 32'(auto_ack), 32'd0);
    tick();
    skit = 1; skit_code = 5'd5; tick();
    iflag = '0; rsttick = 1;
    #1;
    chk("skit_man",   32'(manual_ack), 32'd1);
    chk("skit_code",  32'(ack_code),   32'd5);
    chk("multi_vec",  32'(multi_en),   32'h7FE);
    tick();
    rsttick = 1;
    #1 chk("skit_consumed", 32'(manual_ack), 32'd0);
    tick();

    // Withdrawn request
    iflag = 11'h080; sample = 1; tick();
    chk("wd_req",  32'(irq_req),  32'd1);
    chk("wd_code", 32'(irq_code), 32'd7);
    iflag = '0; sample = 1; tick();
    chk("wd_drop", 32'(irq_req), 32'd0);
    rsttick = 1;
    #1 chk("wd_noack", 32'(auto_ack), 32'd0);
    tick();

    // Reset during ACK drops the pending acks
    iflag = 11'h002; mask = 11'h004; sample = 1; tick();
    accept = 1; tick();
    skit = 1; skit_code = 5'd2; tick();
    mrst = 1; tick();
    rsttick = 1;
    #1;
    chk("rstack_auto", 32'(auto_ack),   32'd0);
    chk("rstack_man",  32'(manual_ack), 32'd0);
    chk("rstack_code", 32'(ack_code),   32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) iflag = 11'($urandom) & 11'($urandom);
      if ($urandom_range(15) == 0) mask = 11'($urandom);
      if ($urandom_range(15) == 0) ie = ~ie;
      sample    = ($urandom_range(3) == 0);
      rsttick   = ($urandom_range(3) == 0);
      accept    = ($urandom_range(5) == 0);
      skit      = ($urandom_range(9) == 0);
      skit_code = 5'($urandom);
      mrst      = ($urandom_range(199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
